// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkg
//  Description : Shared types and helpers for the router packet controller:
//                FSM state encoding, port-index width helper, CRC width.
//  Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

  // CRC is a plain byte-wide XOR over the packet bytes
  localparam int CRC_W = 8;

  // Packet controller states (explicit 3-bit encoding)
  typedef enum logic [2:0] {
    GET_SRC   = 3'd0,
    GET_DST   = 3'd1,
    STORE_HDR = 3'd2,
    GET_SIZE  = 3'd3,
    LOAD_DATA = 3'd4,
    GET_CRC   = 3'd5,
    FULL      = 3'd6,
    DROP      = 3'd7
  } state_t;

  // Width of a port index; never narrower than one bit
  function automatic int port_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/router_pkt_crc.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkt_crc
//  Description : XOR accumulator for the packet check byte. clear restarts
//                the sum (clear+accumulate loads the first byte), match
//                compares the running sum against the incoming byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module router_pkt_crc
  import router_pkg::*;
(
  input  logic             clk1,
  input  logic             reset,
  input  logic             clear,
  input  logic             accumulate,
  input  logic [CRC_W-1:0] data,
  output logic             match
);

  logic [CRC_W-1:0] acc;

  // Running XOR; clear drops the old sum before folding in the new byte
  always_ff @(posedge clk1) begin
    if (reset) begin
      acc <= '0;
    end else if (clear || accumulate) begin
      acc <= (clear ? '0 : acc) ^ (accumulate ? data : '0);
    end
  end

  assign match = (acc == data);

endmodule
`default_nettype wire

// File: rtl/router_pkt_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkt_fsm
//  Description : Input-side packet controller of a 1xN router. Parses
//                src/dst/size/payload/crc bytes, steers write strobes to the
//                selected output FIFO, stalls on FIFO full with a timeout,
//                and drops untrusted or misaddressed packets.
//  Revision    : 1.0 - initial release
// ============================================================================
module router_pkt_fsm
  import router_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int SIZE_W    = 6,
  parameter int MAX_WAIT  = 15,
  parameter bit CRC_EN    = 1'b1
) (
  input  logic                        clk1,
  input  logic                        reset,
  input  logic                        packet_valid_i,
  input  logic [7:0]                  data_i,
  input  logic                        trusted_source,
  input  logic [NUM_PORTS-1:0]        fifo_full,
  output logic [NUM_PORTS-1:0]        write_enb,
  output logic                        get_source,
  output logic                        get_dest,
  output logic                        store_header,
  output logic                        get_size,
  output logic                        load_data,
  output logic                        get_crc,
  output logic                        full_state,
  output logic                        stop_packet_send,
  output logic                        drop_packet,
  output logic                        crc_err,
  output logic [port_w(NUM_PORTS)-1:0] port_sel
);

  localparam int PORT_W = port_w(NUM_PORTS);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_t              state, next_state, ret_state;
  logic [SIZE_W-1:0]   count;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                sel_full, accept, byte_state, do_write;
  logic                dst_ok, crc_match, crc_clear, crc_acc;
  logic [NUM_PORTS-1:0] sel_onehot;

  assign sel_full = fifo_full[port_sel];
  assign dst_ok   = (32'(data_i) < NUM_PORTS);

  // One-hot decode of the registered destination port
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_sel
    assign sel_onehot[p] = (port_sel == PORT_W'(p));
  end

  assign write_enb = do_write ? sel_onehot : '0;

  // Next state, sender throttle and write strobe
  always_comb begin
    next_state       = state;
    stop_packet_send = 1'b0;
    do_write         = 1'b0;
    case (state)
      STORE_HDR, FULL:              stop_packet_send = 1'b1;
      GET_SIZE, LOAD_DATA, GET_CRC: stop_packet_send = sel_full;
      default:                      stop_packet_send = 1'b0;
    endcase
    byte_state = state inside {GET_SRC, GET_DST, GET_SIZE, LOAD_DATA, GET_CRC, DROP};
    accept     = packet_valid_i && !stop_packet_send && byte_state;
    case (state)
      GET_SRC:   if (accept) next_state = trusted_source ? GET_DST : DROP;
      GET_DST:   if (accept) next_state = dst_ok ? STORE_HDR : DROP;
      STORE_HDR: begin
        if (sel_full) next_state = FULL;
        else begin
          do_write   = 1'b1;
          next_state = GET_SIZE;
        end
      end
      GET_SIZE: begin
        if (sel_full) next_state = FULL;
        else if (accept) begin
          do_write   = 1'b1;
          next_state = (data_i[SIZE_W-1:0] == '0) ? GET_CRC : LOAD_DATA;
        end
      end
      LOAD_DATA: begin
        if (sel_full) next_state = FULL;
        else if (accept) begin
          do_write = 1'b1;
          if (count == SIZE_W'(1)) next_state = GET_CRC;
        end
      end
      GET_CRC: begin
        if (sel_full) next_state = FULL;
        else if (accept) begin
          do_write   = 1'b1;
          next_state = GET_SRC;
        end
      end
      // Release beats timeout when both happen in the same cycle
      FULL: begin
        if (!sel_full) next_state = ret_state;
        else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) next_state = DROP;
      end
      DROP:    if (!packet_valid_i) next_state = GET_SRC;
      default: next_state = GET_SRC;
    endcase
  end

  // Moore state flags; DROP raises none of them
  always_comb begin
    get_source   = (state == GET_SRC);
    get_dest     = (state == GET_DST);
    store_header = (state == STORE_HDR);
    get_size     = (state == GET_SIZE);
    load_data    = (state == LOAD_DATA);
    get_crc      = (state == GET_CRC);
    full_state   = (state == FULL);
  end

  // State, stall bookkeeping, payload count and registered pulses
  always_ff @(posedge clk1) begin
    if (reset) begin
      state       <= GET_SRC;
      ret_state   <= GET_SRC;
      count       <= '0;
      wait_cnt    <= '0;
      port_sel    <= '0;
      drop_packet <= 1'b0;
      crc_err     <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == FULL && state != FULL) ret_state <= state;
      if (state == FULL && next_state == FULL) wait_cnt <= wait_cnt + 1'b1;
      else                                     wait_cnt <= '0;
      if (state == GET_DST && accept && dst_ok) port_sel <= data_i[PORT_W-1:0];
      if (state == GET_SIZE && accept)       count <= data_i[SIZE_W-1:0];
      else if (state == LOAD_DATA && accept) count <= count - 1'b1;
      drop_packet <= (next_state == DROP) && (state != DROP);
      crc_err     <= CRC_EN && (state == GET_CRC) && accept && !crc_match;
    end
  end

  assign crc_clear = accept && (state == GET_SRC);
  assign crc_acc   = accept && (state inside {GET_SRC, GET_DST, GET_SIZE, LOAD_DATA});

  router_pkt_crc u_crc (
    .clk1       (clk1),
    .reset      (reset),
    .clear      (crc_clear),
    .accumulate (crc_acc),
    .data       (data_i),
    .match      (crc_match)
  );

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_router_pkt_fsm
//  Description : Self-checking bench for router_pkt_fsm. Directed packets
//                plus randomized traffic, judged by a packet-level model:
//                which bytes reach which FIFO, drop and crc_err pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_router_pkt_fsm;

  localparam int NUM_PORTS = 3;
  localparam int SIZE_W    = 6;
  localparam int MAX_WAIT  = 15;
  localparam bit CRC_EN    = 1'b1;

  logic                 clk1 = 1'b0;
  logic                 reset = 1'b1;
  logic                 packet_valid_i = 1'b0;
  logic [7:0]           data_i = 8'h00;
  logic                 trusted_source = 1'b0;
  logic [NUM_PORTS-1:0] fifo_full = '0;
  logic [NUM_PORTS-1:0] write_enb;
  logic get_source, get_dest, store_header, get_size, load_data, get_crc;
  logic full_state, stop_packet_send, drop_packet, crc_err;
  logic [1:0]           port_sel;

  always #5 clk1 = ~clk1;

  router_pkt_fsm #(
    .NUM_PORTS(NUM_PORTS), .SIZE_W(SIZE_W), .MAX_WAIT(MAX_WAIT), .CRC_EN(CRC_EN)
  ) dut (
    .clk1(clk1), .reset(reset), .packet_valid_i(packet_valid_i), .data_i(data_i),
    .trusted_source(trusted_source), .fifo_full(fifo_full), .write_enb(write_enb),
    .get_source(get_source), .get_dest(get_dest), .store_header(store_header),
    .get_size(get_size), .load_data(load_data), .get_crc(get_crc),
    .full_state(full_state), .stop_packet_send(stop_packet_send),
    .drop_packet(drop_packet), .crc_err(crc_err), .port_sel(port_sel)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] pkt [64];
  int         pkt_len;

  // Observation of the DUT, collected per packet
  logic [NUM_PORTS-1:0] exp_mask;
  int hdr_wr, drop_cnt, crc_cnt, full_cnt, overlap_cnt, wr_stop_cnt, mask_bad;
  logic [7:0] wr_data [$];

  always @(negedge clk1) begin
    if (write_enb != '0) begin
      if (write_enb !== exp_mask) mask_bad++;
      if (store_header) hdr_wr++;
      else begin
        wr_data.push_back(data_i);
        if (stop_packet_send) wr_stop_cnt++;
      end
    end
    if (drop_packet) drop_cnt++;
    if (crc_err) crc_cnt++;
    if (full_state) full_cnt++;
    if (drop_packet && crc_err) overlap_cnt++;
  end

  task automatic clr_mon();
    hdr_wr = 0; drop_cnt = 0; crc_cnt = 0; full_cnt = 0;
    overlap_cnt = 0; wr_stop_cnt = 0; mask_bad = 0;
    wr_data.delete();
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int flags();
    return int'({get_source, get_dest, store_header, get_size, load_data, get_crc,
                 full_state, stop_packet_send, drop_packet, crc_err});
  endfunction

  // Packet = src, dst, size byte, payload[size], crc (XOR of all prior bytes)
  task automatic build_pkt(input logic [7:0] src, input logic [7:0] dst,
                           input int n, input bit crc_good);
    logic [7:0] x;
    pkt[0] = src;
    pkt[1] = dst;
    pkt[2] = {2'($urandom_range(0, 3)), 6'(n)};
    for (int i = 0; i < n; i++) pkt[3+i] = 8'($urandom);
    pkt_len = n + 4;
    x = 8'h00;
    for (int i = 0; i < pkt_len - 1; i++) x = x ^ pkt[i];
    pkt[pkt_len-1] = crc_good ? x : (x ^ 8'($urandom_range(1, 255)));
  endtask

  task automatic fix_crc();
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < pkt_len - 1; i++) x = x ^ pkt[i];
    pkt[pkt_len-1] = x;
  endtask

  // Sender: offers pkt[] bytes, advances on accept (valid && !stop).
  // noisy adds random valid gaps and short fifo_full bursts (<= 4 cycles).
  task automatic run_pkt(input bit trusted, input bit noisy, input int full_idx,
                         input int full_len, output int cycles);
    int idx, guard, fleft, rf_left;
    bit fdone, acc, rfull, rf_cool;
    idx = 0; guard = 0; fleft = 0; rf_left = 0; fdone = 0; rf_cool = 0;
    cycles = 0;
    trusted_source = trusted;
    while (idx < pkt_len && guard < 400) begin
      if (idx == full_idx && !fdone) begin
        fleft = full_len;
        fdone = 1'b1;
      end
      rfull = 1'b0;
      if (noisy) begin
        if (rf_left == 0 && !rf_cool && $urandom_range(0, 5) == 0)
          rf_left = $urandom_range(1, 4);
        if (rf_left > 0) begin
          rfull = 1'b1;
          rf_left--;
          rf_cool = (rf_left == 0);
        end else rf_cool = 1'b0;
      end
      fifo_full      = (fleft > 0 || rfull) ? '1 : '0;
      packet_valid_i = noisy ? ($urandom_range(0, 3) != 0) : 1'b1;
      data_i         = pkt[idx];
      @(negedge clk1);
      acc = packet_valid_i && !stop_packet_send;
      @(posedge clk1);
      #1;
      if (acc) idx++;
      if (fleft > 0) fleft--;
      cycles++;
      guard++;
    end
    if (idx < pkt_len) chk("pkt_send_timeout", idx, pkt_len);
    packet_valid_i = 1'b0;
    fifo_full      = '0;
    repeat (3) @(posedge clk1);
    #1;
  endtask

  task automatic check_pkt(input int n, input bit ok, input bit crc_good, input int dst);
    int mism;
    chk($sformatf("p%0d_drop", n), drop_cnt, ok ? 0 : 1);
    chk($sformatf("p%0d_crc_err", n), crc_cnt, (ok && !crc_good && CRC_EN) ? 1 : 0);
    chk($sformatf("p%0d_hdr_wr", n), hdr_wr, ok ? 1 : 0);
    chk($sformatf("p%0d_n_writes", n), wr_data.size(), ok ? pkt_len - 2 : 0);
    mism = 0;
    if (ok && wr_data.size() == pkt_len - 2)
      for (int i = 0; i < pkt_len - 2; i++)
        if (wr_data[i] !== pkt[i+2]) mism++;
    chk($sformatf("p%0d_wr_data_dst%0d", n, dst), mism + mask_bad, 0);
    chk($sformatf("p%0d_strobe_rules", n), overlap_cnt + wr_stop_cnt, 0);
    chk($sformatf("p%0d_home", n), int'(get_source), 1);
  endtask

  task automatic offer(input logic [7:0] d);
    int g;
    bit acc;
    g = 0; acc = 1'b0;
    packet_valid_i = 1'b1;
    data_i = d;
    while (!acc && g < 20) begin
      @(negedge clk1);
      acc = !stop_packet_send;
      @(posedge clk1);
      #1;
      g++;
    end
    if (!acc) chk("offer_timeout", 0, 1);
  endtask

  initial begin
    int cyc, dst, n;
    bit trusted, ok, crc_good;

    clr_mon();
    exp_mask = 3'b010;

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk1);
    #1;
    reset = 1'b0;
    @(negedge clk1);
    chk("rst_flags", flags(), 10'b10_0000_0000);
    chk("rst_write_enb", int'(write_enb), 0);
    chk("rst_port_sel", int'(port_sel), 0);
    @(posedge clk1);
    #1;

    // Normal packet: 11 01 02 A0 05 crc, port 1, no gaps
    pkt[0] = 8'h11; pkt[1] = 8'h01; pkt[2] = 8'h02; pkt[3] = 8'hA0; pkt[4] = 8'h05;
    pkt_len = 6;
    fix_crc();
    chk("crc_byte_model", int'(pkt[5]), 8'hB7);
    clr_mon();
    run_pkt(1'b1, 1'b0, -1, 0, cyc);
    check_pkt(1, 1'b1, 1'b1, 1);
    chk("min_len_cycles", cyc, 2 + 5);

    // Untrusted source
    clr_mon();
    run_pkt(1'b0, 1'b0, -1, 0, cyc);
    check_pkt(2, 1'b0, 1'b1, 1);

    // Bad destination
    pkt[1] = 8'h03;
    fix_crc();
    clr_mon();
    run_pkt(1'b1, 1'b0, -1, 0, cyc);
    check_pkt(3, 1'b0, 1'b1, 3);

    // Full for 2 cycles at the second payload byte
    pkt[1] = 8'h01;
    fix_crc();
    clr_mon();
    run_pkt(1'b1, 1'b0, 4, 2, cyc);
    check_pkt(4, 1'b1, 1'b1, 1);
    chk("stall_full_cycles", full_cnt, 2);
    chk("stall_len_cycles", cyc, 7 + 3);

    // Full held MAX_WAIT+2 cycles: drop after MAX_WAIT FULL cycles
    clr_mon();
    run_pkt(1'b1, 1'b0, 4, MAX_WAIT + 2, cyc);
    chk("tmo_full_cycles", full_cnt, MAX_WAIT);
    chk("tmo_drop", drop_cnt, 1);
    chk("tmo_writes", hdr_wr * 100 + wr_data.size(), 100 + 2);
    chk("tmo_crc_err", crc_cnt, 0);
    chk("tmo_home", int'(get_source), 1);

    // CRC error
    pkt[5] = 8'h00;
    clr_mon();
    run_pkt(1'b1, 1'b0, -1, 0, cyc);
    check_pkt(6, 1'b1, 1'b0, 1);

    // Reset mid-packet in LOAD_DATA
    trusted_source = 1'b1;
    offer(8'h22);
    offer(8'h02);
    offer(8'h04);
    offer(8'h33);
    @(negedge clk1);
    chk("pre_rst_load_data", int'(load_data) * 10 + int'(port_sel), 12);
    reset = 1'b1;
    data_i = 8'h44;
    @(posedge clk1);
    #1;
    reset = 1'b0;
    packet_valid_i = 1'b0;
    @(negedge clk1);
    chk("midrst_flags", flags(), 10'b10_0000_0000);
    chk("midrst_write_enb", int'(write_enb), 0);
    chk("midrst_port_sel", int'(port_sel), 0);
    repeat (2) @(posedge clk1);
    #1;

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      trusted  = ($urandom_range(0, 5) != 0);
      dst      = $urandom_range(0, 3);
      n        = $urandom_range(0, 6);
      crc_good = ($urandom_range(0, 3) != 0);
      ok       = trusted && (dst < NUM_PORTS);
      build_pkt(8'($urandom), 8'(dst), n, crc_good);
      exp_mask = (dst < NUM_PORTS) ? NUM_PORTS'(1 << dst) : '0;
      clr_mon();
      run_pkt(trusted, ok, -1, 0, cyc);
      check_pkt(100 + k, ok, crc_good, dst);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
